funct_sched: RTL and testbench
==============================

Name: funct_sched

Overview:
- Scheduler and sequencer for the iterative factorial datapath (result = n!, n 4-bit, result 32-bit).
- Shares one multiply/accumulate engine between NREQ requesters using round-robin arbitration.
- Steps the engine one multiply per clock and returns the result with a per-requester done pulse.
- Sits between client blocks and the funct datapath; it is the only owner of the engine.

Parameters:
NREQ, 4, number of requesters (2..8)
NW, 4, operand width of n
RW, 32, result width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req  in  NREQ  per-requester request level
req_n  in  NREQ*NW  per-requester operand; slice i = req_n[i*NW +: NW]
grant  out  NREQ  one-hot, one-cycle pulse; the request is accepted
done  out  NREQ  one-hot, one-cycle pulse; result valid for that requester
result  out  RW  factorial of the granted operand, held until the next done
ovf  out  1  qualified with done; the true product exceeded RW bits
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; grant=0, done=0, result=0, ovf=0, busy=0; rr pointer=0; acc=0, cnt=0, idx=0. A reset during CALC aborts the in-flight job and produces no done.
- FSM states: IDLE -> CALC -> DONE -> IDLE.
- IDLE, at clock edge E0 when |req:
  - Select winner w: first asserted req at or after rr pointer, with circular wrap.
  - Register grant[w]=1 for one cycle.
  - Latch idx=w, cnt=req_n[w], acc=1, ovf_int=0.
  - Go to CALC.
- IDLE with no req: stay in IDLE; all outputs hold their values except the grant and done pulses.
- CALC, each edge:
  - If cnt<=1: result<=acc, ovf<=ovf_int, done[idx]<=1, go to DONE.
  - Otherwise: acc<=low RW bits of (acc*cnt); ovf_int|=(upper bits nonzero); cnt<=cnt-1.
- DONE, one edge: done<=0; rr pointer<=idx+1 modulo NREQ; go to IDLE.
- Latency: done rises max(n,1) cycles after grant rises. Grant-to-next-grant spacing is max(n,1)+2 cycles.
- Handshake: a requester holds req and req_n stable until it sees grant, and deasserts req in the grant cycle. req_n is not sampled again after grant. A req still high after its grant is treated as a new job.
- Arithmetic: 0! = 1! = 1. Overflow first occurs at n=13 for RW=32; result is then the truncated low RW bits.
- Simultaneous requests: exactly one grant per arbitration; the rest wait. Round-robin guarantees each requester is served within NREQ jobs.
- result and ovf change only on the done edge.

Optional Feature:
FUNCT_SCHED_FIXED_PRIO_EN
- Defined: fixed priority; the lowest asserted index always wins and the rr pointer is not implemented.
- Undefined (default): round-robin as described in Behaviour.

Decomposition:
- Package funct_pkg holds:
  - state type (IDLE/CALC/DONE) with 2-bit encoding
  - defaults FUNCT_NW=4 and FUNCT_RW=32
  - constant FUNCT_MAX_EXACT_N=12 (largest n with no overflow at RW=32)
- Sub-module funct_rr_arb: combinational winner select from req and pointer; one-hot output plus index. The macro switch lives inside it.
- The FSM and the multiply datapath stay in funct_sched.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req=4'b1111 -> no grant; all outputs 0; busy=0.
- Single job: req[0]=1, n=5 -> grant[0] pulse; done[0] exactly 5 cycles later; result=120; ovf=0.
- Edge operands:
  - n=0 -> result=1, done 1 cycle after grant
  - n=1 -> result=1, done 1 cycle after grant
  - n=12 -> result=479001600, ovf=0
  - n=13 -> result=1932053504 (13! mod 2^32), ovf=1
- Contention: req=4'b1111 held, n=3 for all -> grant order 0,1,2,3,0; each done shows result=6. With FUNCT_SCHED_FIXED_PRIO_EN defined and req[0] held continuously, requester 0 is granted every job.
- Reset mid-job: req[2], n=15; drop reset 4 cycles after grant -> no done[2]; after release, result=0; req[1], n=4 -> result=24.
- Sweep: n=0..15 sequentially on requester 3 -> each result matches a reference model; ovf=1 exactly for n>=13.

Source files
------------

// File: rtl/funct_pkg.sv
// funct_pkg: shared types and constants for the factorial scheduler slice.
//   state_e            scheduler FSM state (IDLE/CALC/DONE), 2-bit encoding
//   FUNCT_NW/FUNCT_RW  default operand and result widths
//   FUNCT_MAX_EXACT_N  largest n whose factorial fits in a 32-bit result
package funct_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FUNCT_NW          = 4;
    localparam int FUNCT_RW          = 32;
    localparam int FUNCT_MAX_EXACT_N = 12;

endpackage

// File: rtl/funct_rr_arb.sv
// funct_rr_arb: combinational winner select for the factorial scheduler.
//   req_i   per-requester request level
//   ptr_i   round-robin start index (first candidate examined)
//   gnt_o   one-hot winner (all zero when no request)
//   idx_o   binary index of the winner
//   any_o   at least one request is asserted
// Build option: FUNCT_SCHED_FIXED_PRIO_EN selects fixed priority (lowest
// asserted index wins, ptr_i is ignored); default is round-robin from ptr_i.
module funct_rr_arb #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic [IW-1:0] start;
    logic [IW-1:0] cand;
    logic          found;

`ifdef FUNCT_SCHED_FIXED_PRIO_EN
    assign start = '0;
`else
    assign start = ptr_i;
`endif

    // Scan NREQ candidates beginning at start, wrapping modulo NREQ; the
    // first asserted request wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IW'((32'(start) + k) % NREQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/funct_sched.sv
// funct_sched: shares one iterative factorial engine between NREQ requesters.
//   clk     system clock, rising edge
//   reset   asynchronous active-low reset
//   req     per-requester request level
//   req_n   per-requester operand, slice i = req_n[i*NW +: NW]
//   grant   one-hot, one-cycle pulse when a request is accepted
//   done    one-hot, one-cycle pulse when result is valid for that requester
//   result  n! of the granted operand (low RW bits), held until next done
//   ovf     qualified with done; the exact product exceeded RW bits
//   busy    high whenever the FSM is not IDLE
// Build option: FUNCT_SCHED_FIXED_PRIO_EN selects fixed-priority arbitration
// and removes the round-robin pointer.
module funct_sched
    import funct_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int NW   = FUNCT_NW,
    parameter int RW   = FUNCT_RW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*NW-1:0] req_n,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic [RW-1:0]     result,
    output logic              ovf,
    output logic              busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q,  done_d;
    logic [RW-1:0]     result_q, result_d;
    logic              ovf_q,   ovf_d;
    logic [RW-1:0]     acc_q,   acc_d;
    logic [NW-1:0]     cnt_q,   cnt_d;
    logic [IW-1:0]     idx_q,   idx_d;
    logic              ovfint_q, ovfint_d;

    logic [IW-1:0]     ptr;
    logic [NREQ-1:0]   win_oh;
    logic [IW-1:0]     win_idx;
    logic              win_any;
    logic [RW+NW-1:0]  prod;

    funct_rr_arb #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_i (req),
        .ptr_i (ptr),
        .gnt_o (win_oh),
        .idx_o (win_idx),
        .any_o (win_any)
    );

`ifdef FUNCT_SCHED_FIXED_PRIO_EN
    assign ptr = '0;
`else
    logic [IW-1:0] ptr_q, ptr_d;

    // Next search starts just after the requester that was last served.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == DONE) begin
            ptr_d = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`endif

    // Full-width product so bits above RW reveal truncation at each step.
    assign prod = (RW+NW)'(acc_q) * (RW+NW)'(cnt_q);

    always_comb begin
        state_d  = state_q;
        grant_d  = '0;
        done_d   = '0;
        result_d = result_q;
        ovf_d    = ovf_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        ovfint_d = ovfint_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    grant_d  = win_oh;
                    idx_d    = win_idx;
                    cnt_d    = req_n[win_idx*NW +: NW];
                    acc_d    = RW'(1);
                    ovfint_d = 1'b0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                if (cnt_q <= NW'(1)) begin
                    result_d      = acc_q;
                    ovf_d         = ovfint_q;
                    done_d[idx_q] = 1'b1;
                    state_d       = DONE;
                end else begin
                    acc_d    = prod[RW-1:0];
                    ovfint_d = ovfint_q | (|prod[RW+NW-1:RW]);
                    cnt_d    = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            done_q   <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            ovfint_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            ovfint_q <= ovfint_d;
        end
    end

    assign grant  = grant_q;
    assign done   = done_q;
    assign result = result_q;
    assign ovf    = ovf_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_funct_sched.sv
// tb_funct_sched: scoreboard bench for funct_sched. Drivers push expected
// grants and results into queues; a negedge monitor pops and compares
// whenever the DUT pulses grant or done.
module tb_funct_sched;
    import funct_pkg::*;

    localparam int NREQ = 4;
    localparam int NW   = 4;
    localparam int RW   = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*NW-1:0] req_n;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic [RW-1:0]     result;
    logic              ovf;
    logic              busy;

    funct_sched #(
        .NREQ (NREQ),
        .NW   (NW),
        .RW   (RW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .req_n  (req_n),
        .grant  (grant),
        .done   (done),
        .result (result),
        .ovf    (ovf),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned who;
        logic [RW-1:0] res;
        logic          ovf;
        int unsigned   lat;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned gexp_q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned cyc  = 0;
    int unsigned gcyc = 0;
    int unsigned mw;
    exp_t        me;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Exact factorial in 64 bits; 15! fits comfortably.
    function automatic void fact(input int unsigned n, output logic [RW-1:0] r, output logic o);
        longint unsigned p = 1;
        for (int unsigned k = 2; k <= n; k++) p = p * k;
        r = p[RW-1:0];
        o = (p > 64'hFFFF_FFFF);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every grant/done pulse is checked against the queues.
    always @(negedge clk) begin
        if (grant !== '0) begin
            if (gexp_q.size() == 0) begin
                check("unexpected_grant", 64'(grant), 64'd0);
            end else begin
                mw = gexp_q.pop_front();
                check("grant_onehot", 64'(grant), 64'(1) << mw);
                gcyc = cyc;
            end
        end
        if (done !== '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                me = exp_q.pop_front();
                check("done_onehot", 64'(done), 64'(1) << me.who);
                check("result", 64'(result), 64'(me.res));
                check("ovf", 64'(ovf), 64'(me.ovf));
                check("latency", 64'(cyc - gcyc), 64'(me.lat));
            end
        end
    end

    task automatic set_n(input int unsigned who, input logic [NW-1:0] n);
        req_n[who*NW +: NW] = n;
    endtask

    task automatic wait_grant(input int unsigned who);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (grant[who]) return;
        end
        check("grant_timeout", 64'(grant[who]), 64'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) return;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic job(input int unsigned who, input logic [NW-1:0] n,
                       input logic [RW-1:0] r, input logic o);
        exp_t e;
        e.who = who;
        e.res = r;
        e.ovf = o;
        e.lat = (n == 0) ? 1 : int'(n);
        @(negedge clk);
        set_n(who, n);
        req[who] = 1'b1;
        gexp_q.push_back(who);
        exp_q.push_back(e);
        wait_grant(who);
        req[who] = 1'b0;
        wait_drain();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Directed vectors: {who, n, result, ovf}
    typedef struct {
        int unsigned   who;
        logic [NW-1:0] n;
        logic [RW-1:0] res;
        logic          ovf;
    } vec_t;

    vec_t vecs[5] = '{
        '{0, 4'd5,  32'd120,        1'b0},
        '{1, 4'd0,  32'd1,          1'b0},
        '{2, 4'd1,  32'd1,          1'b0},
        '{0, 4'd12, 32'd479001600,  1'b0},
        '{3, 4'd13, 32'd1932053504, 1'b1}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [RW-1:0] mr;
        logic          mo;
        exp_t          e;
        int            g;

        // Reset held with all requests asserted: nothing may be granted.
        reset = 1'b0;
        req   = '1;
        req_n = {NREQ{4'd5}};
        repeat (3) @(negedge clk);
        check("rst_grant",  64'(grant),  64'd0);
        check("rst_done",   64'(done),   64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_ovf",    64'(ovf),    64'd0);
        check("rst_busy",   64'(busy),   64'd0);
        req   = '0;
        reset = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) job(vecs[i].who, vecs[i].n, vecs[i].res, vecs[i].ovf);

        // Contention from a fresh pointer: all four requesters hold req.
        pulse_reset();
        @(negedge clk);
        req   = '1;
        req_n = {NREQ{4'd3}};
        for (int unsigned i = 0; i < 5; i++) begin
`ifdef FUNCT_SCHED_FIXED_PRIO_EN
            e.who = 0;
`else
            e.who = i % NREQ;
`endif
            e.res = 32'd6;
            e.ovf = 1'b0;
            e.lat = 3;
            gexp_q.push_back(e.who);
            exp_q.push_back(e);
        end
        g = 0;
        for (int i = 0; i < 100 && g < 5; i++) begin
            @(negedge clk);
            if (grant !== '0) g++;
        end
        req = '0;
        check("contention_grants", 64'(g), 64'd5);
        wait_drain();

        // Reset in the middle of a long job: no done, result cleared.
        @(negedge clk);
        set_n(2, 4'd15);
        req[2] = 1'b1;
        gexp_q.push_back(2);
        wait_grant(2);
        req[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_busy",   64'(busy),   64'd0);
        check("midrst_result", 64'(result), 64'd0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst_done",   64'(done),   64'd0);
        check("postrst_result", 64'(result), 64'd0);
        job(1, 4'd4, 32'd24, 1'b0);

        // Sweep n = 0..15 on requester 3 against the exact model.
        for (int unsigned n = 0; n < 16; n++) begin
            fact(n, mr, mo);
            job(3, NW'(n), mr, mo);
        end

        repeat (3) @(negedge clk);
        check("sb_results_left", 64'(exp_q.size()),  64'd0);
        check("sb_grants_left",  64'(gexp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
